// File: rtl/lmem_amo_bank_pkg.sv
// rtl/lmem_amo_bank_pkg.sv - op encodings and helpers shared by the local-memory bank
package lmem_amo_bank_pkg;

  localparam int LMEM_OP_BITS = 3;

  localparam logic [LMEM_OP_BITS-1:0] LMEM_OP_LOAD  = 3'd0;
  localparam logic [LMEM_OP_BITS-1:0] LMEM_OP_STORE = 3'd1;
  localparam logic [LMEM_OP_BITS-1:0] LMEM_OP_ADD   = 3'd2;
  localparam logic [LMEM_OP_BITS-1:0] LMEM_OP_SWAP  = 3'd3;
  localparam logic [LMEM_OP_BITS-1:0] LMEM_OP_AND   = 3'd4;
  localparam logic [LMEM_OP_BITS-1:0] LMEM_OP_OR    = 3'd5;
  localparam logic [LMEM_OP_BITS-1:0] LMEM_OP_MIN   = 3'd6;
  localparam logic [LMEM_OP_BITS-1:0] LMEM_OP_MAX   = 3'd7;

  function automatic logic lmem_is_amo(input logic [LMEM_OP_BITS-1:0] op);
    return op >= LMEM_OP_ADD;
  endfunction

endpackage

// File: rtl/lmem_amo_alu.sv
// rtl/lmem_amo_alu.sv - combinational atomic op: (op, old value, operand) -> value to write back
module lmem_amo_alu
  import lmem_amo_bank_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [LMEM_OP_BITS-1:0] op,
  input  logic [DATA_W-1:0]       old_value,
  input  logic [DATA_W-1:0]       operand,
  output logic [DATA_W-1:0]       new_value
);

  always_comb begin
    new_value = old_value;
    case (op)
      LMEM_OP_ADD:  new_value = old_value + operand;
      LMEM_OP_SWAP: new_value = operand;
      LMEM_OP_AND:  new_value = old_value & operand;
      LMEM_OP_OR:   new_value = old_value | operand;
      LMEM_OP_MIN:  new_value = ($signed(old_value) < $signed(operand)) ? old_value : operand;
      LMEM_OP_MAX:  new_value = ($signed(old_value) > $signed(operand)) ? old_value : operand;
      default:      new_value = old_value;
    endcase
  end

endmodule

// File: rtl/lmem_amo_bank.sv
// rtl/lmem_amo_bank.sv - local-memory bank with atomic read-modify-write and one-cycle write forwarding
module lmem_amo_bank
  import lmem_amo_bank_pkg::*;
#(
  parameter int WORDS      = 1024,
  parameter int WORD_SIZE  = 4,
  parameter int TAG_WIDTH  = 16,
  parameter int AMO_ENABLE = 1,
  parameter int WRITE_RSP  = 0,
  parameter int ADDR_WIDTH = $clog2(WORDS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic [LMEM_OP_BITS-1:0]  req_op,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  input  logic [WORD_SIZE-1:0]     req_byteen,
  input  logic [WORD_SIZE*8-1:0]   req_data,
  input  logic [TAG_WIDTH-1:0]     req_tag,
  output logic                     req_ready,
  output logic                     rsp_valid,
  output logic [WORD_SIZE*8-1:0]   rsp_data,
  output logic [TAG_WIDTH-1:0]     rsp_tag,
  input  logic                     rsp_ready
);

  localparam int DATA_W = WORD_SIZE * 8;

  logic [DATA_W-1:0]       mem [WORDS];
  logic [DATA_W-1:0]       ram_rdata;

  logic                    s1_valid;
  logic [LMEM_OP_BITS-1:0] s1_op;
  logic [ADDR_WIDTH-1:0]   s1_addr;
  logic [DATA_W-1:0]       s1_operand;
  logic [TAG_WIDTH-1:0]    s1_tag;
  logic [WORD_SIZE-1:0]    s1_fwd_be;
  logic [DATA_W-1:0]       s1_fwd_data;

  logic                    hold_valid;
  logic [DATA_W-1:0]       hold_data;
  logic [TAG_WIDTH-1:0]    hold_tag;

  logic                    fwd_valid;
  logic [ADDR_WIDTH-1:0]   fwd_addr;
  logic [WORD_SIZE-1:0]    fwd_be;
  logic [DATA_W-1:0]       fwd_data;

  logic                    fire, amo_wb, s1_rsp, ram_we;
  logic [LMEM_OP_BITS-1:0] req_op_eff;
  logic [DATA_W-1:0]       s1_old, amo_new, ram_wdata;
  logic [ADDR_WIDTH-1:0]   ram_waddr;
  logic [WORD_SIZE-1:0]    ram_wbe;

  // With atomics compiled out, every AMO encoding degrades to a plain LOAD.
  assign req_op_eff = (AMO_ENABLE == 0 && lmem_is_amo(req_op)) ? LMEM_OP_LOAD : req_op;

  assign amo_wb    = s1_valid && lmem_is_amo(s1_op) && !reset;
  assign s1_rsp    = s1_valid && (s1_op != LMEM_OP_STORE || WRITE_RSP != 0);
  assign rsp_valid = !reset && (hold_valid || s1_rsp);
  assign req_ready = !reset && !amo_wb && !(rsp_valid && !rsp_ready);
  assign fire      = req_valid && req_ready;

  always_comb begin
    s1_old = ram_rdata;
    for (int b = 0; b < WORD_SIZE; b++) begin
      if (s1_fwd_be[b]) s1_old[b*8 +: 8] = s1_fwd_data[b*8 +: 8];
    end
  end

  lmem_amo_alu #(.DATA_W(DATA_W)) u_alu (
    .op        (s1_op),
    .old_value (s1_old),
    .operand   (s1_operand),
    .new_value (amo_new)
  );

  // The single RAM port is shared: an AMO writeback owns it because req_ready is low that cycle.
  assign ram_we    = amo_wb || (fire && req_op_eff == LMEM_OP_STORE);
  assign ram_waddr = amo_wb ? s1_addr : req_addr;
  assign ram_wbe   = amo_wb ? '1 : req_byteen;
  assign ram_wdata = amo_wb ? amo_new : req_data;

  assign rsp_data = hold_valid ? hold_data
                  : (s1_op == LMEM_OP_STORE) ? '0 : s1_old;
  assign rsp_tag  = hold_valid ? hold_tag : s1_tag;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < WORD_SIZE; b++) begin
        if (ram_wbe[b]) mem[ram_waddr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      end
    end
    if (fire && req_op_eff != LMEM_OP_STORE) ram_rdata <= mem[req_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      hold_valid <= 1'b0;
      fwd_valid  <= 1'b0;
    end else begin
      s1_valid   <= fire;
      hold_valid <= rsp_valid && !rsp_ready;
      fwd_valid  <= ram_we;
    end
  end

  always_ff @(posedge clk) begin
    if (fire) begin
      s1_op       <= req_op_eff;
      s1_addr     <= req_addr;
      s1_operand  <= req_data;
      s1_tag      <= req_tag;
      s1_fwd_be   <= (fwd_valid && fwd_addr == req_addr) ? fwd_be : '0;
      s1_fwd_data <= fwd_data;
    end
    if (!hold_valid) begin
      hold_data <= rsp_data;
      hold_tag  <= rsp_tag;
    end
    fwd_addr <= ram_waddr;
    fwd_be   <= ram_wbe;
    fwd_data <= ram_wdata;
  end

  amo_full_word: assert property (@(posedge clk) disable iff (reset)
    (fire && lmem_is_amo(req_op_eff)) |-> (&req_byteen));

endmodule
